rng_arbiter: RTL
================

# rng_arbiter

- Shares one 8-bit Galois LFSR among up to NREQ game-logic requesters (fruit spawn position, fruit type, spawn delay, bomb chance).
- Sequences seeding of the LFSR, free-runs it every cycle so that player-timing entropy shows up in the values, and grants one random word per cycle to a requester chosen by the arbiter.
- Sits between the spawn controllers and the LFSR datapath; no requester drives the LFSR directly.

## Interface
- NREQ, 4 — number of requesters (2..8)
- WIDTH, 8 — LFSR and output word width
- TAPS, 8'hB8 — Galois feedback mask (maximal, period 255)
- SEED_DEFAULT, 8'd2 — seed used after reset and whenever a zero seed is presented
- clk input 1 — single system clock, all state on rising edge
- rst input 1 — asynchronous, active-low reset
- seed input WIDTH — seed value, sampled only while seed_load=1 in SEED state
- seed_load input 1 — request reseed; in RUN forces a return to SEED
- req input NREQ — per-requester request, level, held until granted
- gnt output NREQ — registered one-hot grant pulse, one cycle wide
- rnd output WIDTH — registered random word, valid when rnd_valid=1
- rnd_valid output 1 — high exactly in cycles where gnt is nonzero
- seeding output 1 — high while FSM is in SEED

## Operation
- FSM states: SEED, RUN. Reset state SEED.
- SEED, one cycle: lfsr <= (seed_load && seed!=0) ? seed : SEED_DEFAULT; gnt, rnd_valid forced 0; next state RUN.
- RUN, seed_load=1: next state SEED; no grant issued that cycle; lfsr holds.
- RUN, seed_load=0:
  - lfsr <= step(lfsr) every cycle, with or without requests.
  - step(s) = (s >> 1) ^ (s[0] ? TAPS : 0).
- Grant, RUN with seed_load=0 and req != 0:
  - gnt <= onehot(winner); rnd <= current lfsr (pre-step value); rnd_valid <= 1.
- No request: gnt <= 0, rnd_valid <= 0, rnd holds its last value.
- Requester owns the request protocol:
  - Drop req in the cycle gnt is seen, or keep it high to get a further word.
  - A req held across a grant is treated as a new request.
- Zero-state guard: the lfsr register never holds 0. Zero seed is substituted; the step function cannot reach 0 from a nonzero state.
- Reset values: gnt=0, rnd=0, rnd_valid=0, seeding=1, lfsr=SEED_DEFAULT, arbitration pointer=NREQ-1 (so requester 0 is favoured first).

## Timing
- Grant latency: req sampled at edge k, gnt/rnd/rnd_valid valid after edge k; at most one grant per cycle.
- First grant possible on the second rising edge after rst deasserts (edge 1 performs SEED).
- seed_load in RUN at edge k:
  - SEED runs at edge k+1.
  - The next grant is possible at edge k+2.
- rst assertion mid-grant clears gnt and rnd_valid immediately (asynchronous); the pointer returns to its reset value.
- Simultaneous seed_load and req in RUN: seed_load wins, the request stays pending.

## Configuration
- RNG_ROUND_ROBIN_EN defined: rotating priority.
  - The search starts at index (last_winner+1) mod NREQ.
  - The pointer updates only on a grant.
  - Every continuously asserted req is granted within NREQ cycles.
- Undefined: fixed priority; the lowest asserted index wins and the pointer logic is removed.

## Structure
- Package rng_pkg holds:
  - the state enum {SEED, RUN}
  - the default TAPS and SEED_DEFAULT constants
  - the step function
- Sub-module rng_rr_pick: combinational pick of the winner from req and the pointer, output one-hot.
  - Contains both the fixed-priority and the round-robin variant under RNG_ROUND_ROBIN_EN.
- The LFSR register, FSM and output registers live in rng_arbiter.

## Test plan
- Seed sequence: rst low, then high with seed_load=1, seed=8'h02, then req[0] held from the first RUN cycle.
  - Required: rnd = 02, 01, B8, 5C, 2E, 17, B3 on successive grants.
  - gnt=0001 with rnd_valid=1 in every one of those cycles.
- Zero seed: reseed with seed=0.
  - Required: lfsr loads 02, and the first grant after reseed returns 02.
- Round robin (RNG_ROUND_ROBIN_EN defined): req=1111 held.
  - Required: gnt = 0001, 0010, 0100, 1000, 0001.
  - Without the macro, gnt stays 0001.
- Period: free-run 255 RUN cycles with no req.
  - Required: lfsr returns to 02 and never equals 00.
  - Required: gnt and rnd_valid stay 0.
- seed_load collision: seed_load=1 with req=0100 in RUN.
  - Required: no gnt that edge and seeding=1 the next cycle.
  - Required: gnt=0100 two edges later.
- Async reset mid-grant: drop rst while gnt=0010.
  - Required: gnt=0, rnd_valid=0, rnd=0 and seeding=1 before the next clock edge.

Source files
------------

// File: rtl/rng_pkg.sv
// rng_pkg: shared state enum, LFSR defaults and Galois step function
package rng_pkg;

    typedef enum logic {SEED, RUN} state_t;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] TAPS_DEF = 8'hB8;
    localparam logic [LFSR_W-1:0] SEED_DEF = 8'd2;

    function automatic logic [LFSR_W-1:0] step(input logic [LFSR_W-1:0] s, input logic [LFSR_W-1:0] taps);
        return (s >> 1) ^ (s[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/rng_rr_pick.sv
// rng_rr_pick: one-hot winner pick; rotating priority when RNG_ROUND_ROBIN_EN is defined, else lowest index
module rng_rr_pick
    import rng_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
`ifdef RNG_ROUND_ROBIN_EN
    input  logic [PW-1:0]   ptr,
`endif
    output logic [NREQ-1:0] gnt
);

`ifdef RNG_ROUND_ROBIN_EN
    logic [NREQ-1:0] rot, low;

    // rotate so the requester after the last winner sits at bit 0, take the lowest set bit, rotate back
    always_comb begin
        rot = NREQ'({req, req} >> (int'(ptr) + 1));
        low = rot & (~rot + NREQ'(1));
        gnt = NREQ'(({low, low} << (int'(ptr) + 1)) >> NREQ);
    end
`else
    // lowest asserted index wins
    assign gnt = req & (~req + NREQ'(1));
`endif

endmodule

// File: rtl/rng_arbiter.sv
// rng_arbiter: seeds and free-runs a shared Galois LFSR, granting one word per cycle (RNG_ROUND_ROBIN_EN selects rotating priority)
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int                NREQ         = 4,
    parameter int                WIDTH        = LFSR_W,
    parameter logic [WIDTH-1:0]  TAPS         = TAPS_DEF,
    parameter logic [WIDTH-1:0]  SEED_DEFAULT = SEED_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_load,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [WIDTH-1:0] rnd,
    output logic             rnd_valid,
    output logic             seeding
);

    localparam int PW = $clog2(NREQ);

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [NREQ-1:0]  pick;

    assign seeding = (state == SEED);

`ifdef RNG_ROUND_ROBIN_EN
    logic [PW-1:0] ptr, win;

    rng_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (.req(req), .ptr(ptr), .gnt(pick));

    // encode the one-hot winner for the pointer
    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick[i]) win = PW'(i);
    end

    // pointer remembers the last winner and moves only on a grant
    always_ff @(posedge clk or negedge rst)
        if (!rst) ptr <= PW'(NREQ - 1);
        else if (state == RUN && !seed_load && |req) ptr <= win;
`else
    rng_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (.req(req), .gnt(pick));
`endif

    // seeding FSM, free-running LFSR and registered grant outputs
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= SEED;
            lfsr      <= SEED_DEFAULT;
            gnt       <= '0;
            rnd       <= '0;
            rnd_valid <= 1'b0;
        end else if (state == SEED) begin
            lfsr      <= (seed_load && seed != '0) ? seed : SEED_DEFAULT;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            state     <= RUN;
        end else if (seed_load) begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
            state     <= SEED;
        end else begin
            lfsr      <= step(lfsr, TAPS);
            gnt       <= pick;
            rnd_valid <= |req;
            if (|req) rnd <= lfsr;
        end

endmodule
